// File: rtl/rwc_chal_seq.sv
// Challenge sequencer: issues NUM_CHAL address/LFSR challenges to a collision
// generator, waits on its available handshake, and returns write^clean words to the host.
module rwc_chal_seq #(
  parameter int NUM_CHAL = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        gen_enable,
  output logic [9:0]  cha_addr,
  output logic [31:0] cha_data,
  input  logic        available,
  input  logic [31:0] rsp_write,
  input  logic [31:0] rsp_clean,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [9:0]  rsp_index,
  output logic        done,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [9:0]    LAST = 10'(NUM_CHAL - 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LO, WAIT_HI, CAPTURE, PRESENT, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [9:0]    index;
  logic [31:0]   lfsr, lfsr_nxt, seed_ok;
  logic          to_hit, xfer;

  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  assign seed_ok  = (seed == 32'h0) ? 32'h1 : seed;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    to_hit     = 1'b0;
    xfer       = 1'b0;
    busy       = (state != IDLE);
    gen_enable = (state == ISSUE);
    rsp_valid  = (state == PRESENT);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (!available) state_nxt = WAIT_LO;
        else if (cnt == TLIM) begin
          state_nxt = DONE;
          to_hit    = 1'b1;
        end
      end
      WAIT_LO: begin
        if (available) state_nxt = WAIT_HI;
        else if (cnt == TLIM) begin
          state_nxt = DONE;
          to_hit    = 1'b1;
        end
      end
      WAIT_HI: state_nxt = CAPTURE;
      CAPTURE: state_nxt = PRESENT;
      PRESENT: begin
        if (rsp_ready) begin
          xfer      = 1'b1;
          state_nxt = (index == LAST) ? DONE : ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      index       <= '0;
      lfsr        <= 32'h1;
      cha_addr    <= '0;
      cha_data    <= '0;
      rsp_data    <= '0;
      rsp_index   <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Any state change clears the counter, which covers entry to ISSUE and WAIT_LO.
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        index       <= '0;
        lfsr        <= seed_ok;
        cha_addr    <= base_addr;
        cha_data    <= seed_ok;
        timeout_err <= 1'b0;
      end
      if (to_hit) timeout_err <= 1'b1;
      if (state == CAPTURE) begin
        rsp_data  <= rsp_write ^ rsp_clean;
        rsp_index <= index;
      end
      // Challenge registers change only here, so they hold from ISSUE through CAPTURE.
      if (xfer && index != LAST) begin
        index    <= index + 10'd1;
        lfsr     <= lfsr_nxt;
        cha_addr <= cha_addr + 10'd1;
        cha_data <= lfsr_nxt;
      end
    end
  end
endmodule
